// File: rtl/waterfall_multi.sv
// waterfall_multi: parametrised LED pattern sequencer.
//   Drives N_LED outputs with a rotate-left, rotate-right, bounce or fill pattern
//   advanced every PERIODx clocks (PERIODx chosen by freq_set at start).
//   Optional build macro: WATERFALL_PWM_EN adds a brightness input and PWM gating
//   of the LED drive (one-cycle registered lag behind the pattern register).
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   start       pulse, begins a sequence (sampled only in IDLE)
//   stop        pulse, aborts the sequence and returns to IDLE (highest priority)
//   pause       level, freezes the sequence while high
//   freq_set    period select, latched on start
//   mode        00 rot-left, 01 rot-right, 10 bounce, 11 fill; latched on start
//   brightness  PWM duty (WATERFALL_PWM_EN builds only)
//   led         registered LED drive
//   busy        high in RUN or PAUSE
//   step_pulse  one-cycle strobe on each pattern advance
module waterfall_multi #(
  parameter int          N_LED   = 8,
  parameter int          CNT_W   = 32,
  parameter int unsigned PERIOD0 = 10_000_000,
  parameter int unsigned PERIOD1 = 20_000_000,
  parameter int unsigned PERIOD2 = 50_000_000,
  parameter int unsigned PERIOD3 = 100_000_000,
  parameter int          PWM_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [1:0]       freq_set,
  input  logic [1:0]       mode,
`ifdef WATERFALL_PWM_EN
  input  logic [PWM_W-1:0] brightness,
`endif
  output logic [N_LED-1:0] led,
  output logic             busy,
  output logic             step_pulse
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [N_LED-1:0] PAT_LSB = N_LED'(1);
  localparam logic [N_LED-1:0] PAT_MSB = {1'b1, {(N_LED-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_nx;
  dir_t             dir_q, dir_nx;
  logic [N_LED-1:0] pat_q, pat_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [1:0]       freq_q, freq_nx;
  logic [1:0]       mode_q, mode_nx;
  logic             pulse_q, pulse_nx;

  logic [CNT_W-1:0] period;
  logic [N_LED-1:0] pat_adv;
  dir_t             dir_adv;

  always_comb begin
    unique case (freq_q)
      2'b00:   period = CNT_W'(PERIOD0);
      2'b01:   period = CNT_W'(PERIOD1);
      2'b10:   period = CNT_W'(PERIOD2);
      default: period = CNT_W'(PERIOD3);
    endcase
  end

  // Next pattern for one advance. Bounce turns around on the end LED itself,
  // so each end position is shown for exactly one step.
  always_comb begin
    pat_adv = pat_q;
    dir_adv = dir_q;
    unique case (mode_q)
      2'b00: pat_adv = {pat_q[N_LED-2:0], pat_q[N_LED-1]};
      2'b01: pat_adv = {pat_q[0], pat_q[N_LED-1:1]};
      2'b10: begin
        if (dir_q == DIR_UP) begin
          if (pat_q[N_LED-1]) begin
            pat_adv = pat_q >> 1;
            dir_adv = DIR_DOWN;
          end else begin
            pat_adv = pat_q << 1;
          end
        end else begin
          if (pat_q[0]) begin
            pat_adv = pat_q << 1;
            dir_adv = DIR_UP;
          end else begin
            pat_adv = pat_q >> 1;
          end
        end
      end
      default: pat_adv = (&pat_q) ? PAT_LSB : {pat_q[N_LED-2:0], 1'b1};
    endcase
  end

  always_comb begin
    state_nx = state_q;
    dir_nx   = dir_q;
    pat_nx   = pat_q;
    cnt_nx   = cnt_q;
    freq_nx  = freq_q;
    mode_nx  = mode_q;
    pulse_nx = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_nx = S_RUN;
          freq_nx  = freq_set;
          mode_nx  = mode;
          pat_nx   = (mode == 2'b01) ? PAT_MSB : PAT_LSB;
          cnt_nx   = CNT_ONE;
          dir_nx   = DIR_UP;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nx = S_IDLE;
          pat_nx   = PAT_LSB;
          cnt_nx   = CNT_ONE;
          dir_nx   = DIR_UP;
        end else if (pause) begin
          state_nx = S_PAUSE;
        end else if (cnt_q == period) begin
          cnt_nx   = CNT_ONE;
          pat_nx   = pat_adv;
          dir_nx   = dir_adv;
          pulse_nx = 1'b1;
        end else begin
          cnt_nx = cnt_q + CNT_ONE;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_nx = S_IDLE;
          pat_nx   = PAT_LSB;
          cnt_nx   = CNT_ONE;
          dir_nx   = DIR_UP;
        end else if (!pause) begin
          state_nx = S_RUN;
        end
      end
      default: begin
        state_nx = S_IDLE;
        pat_nx   = PAT_LSB;
        cnt_nx   = CNT_ONE;
        dir_nx   = DIR_UP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_UP;
      pat_q   <= PAT_LSB;
      cnt_q   <= CNT_ONE;
      freq_q  <= '0;
      mode_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_nx;
      dir_q   <= dir_nx;
      pat_q   <= pat_nx;
      cnt_q   <= cnt_nx;
      freq_q  <= freq_nx;
      mode_q  <= mode_nx;
      pulse_q <= pulse_nx;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign step_pulse = pulse_q;

`ifdef WATERFALL_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;
  logic [N_LED-1:0] led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      led_q   <= PAT_LSB;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      led_q   <= pat_q & {N_LED{pwm_cnt < brightness}};
    end
  end

  assign led = led_q;
`else
  assign led = pat_q;
`endif

endmodule

// File: tb/tb_waterfall_multi.sv
// tb_waterfall_multi: directed bench for waterfall_multi with a step-index model.
//   The model tracks run/pause state, latched period/mode, the step count k and the
//   clocks-since-step counter; the expected pattern is computed arithmetically from k.
module tb_waterfall_multi;
  localparam int N  = 8;
  localparam int P0 = 3;
  localparam int P1 = 5;
  localparam int P2 = 2;
  localparam int P3 = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] freq_set = 2'b00;
  logic [1:0] mode = 2'b00;
`ifdef WATERFALL_PWM_EN
  logic [3:0] brightness = 4'd15;
`endif
  logic [N-1:0] led;
  logic         busy;
  logic         step_pulse;

  int  checks = 0;
  int  errors = 0;
  bit  cmp_en = 1'b0;

  waterfall_multi #(
    .N_LED  (N),
    .CNT_W  (32),
    .PERIOD0(P0),
    .PERIOD1(P1),
    .PERIOD2(P2),
    .PERIOD3(P3),
    .PWM_W  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .freq_set  (freq_set),
    .mode      (mode),
`ifdef WATERFALL_PWM_EN
    .brightness(brightness),
`endif
    .led       (led),
    .busy      (busy),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       run;
    logic       paused;
    logic [1:0] md;
    int         per;
    int         k;
    int         c;
    logic       pulse;
    logic [3:0] pwm;
    logic [7:0] led;
  } model_t;

  localparam model_t M_RST = '{run: 1'b0, paused: 1'b0, md: 2'b00, per: P0, k: 0,
                               c: 1, pulse: 1'b0, pwm: 4'd0, led: 8'h01};

  model_t m, m_nx;

  function automatic int period_of(input logic [1:0] f);
    case (f)
      2'b00:   return P0;
      2'b01:   return P1;
      2'b10:   return P2;
      default: return P3;
    endcase
  endfunction

  // Pattern after k steps, derived directly from the pattern definitions.
  function automatic logic [7:0] pattern_of(input logic [1:0] md, input int k);
    int p;
    case (md)
      2'b00: return 8'(1 << (k % N));
      2'b01: return 8'(1 << (N - 1 - (k % N)));
      2'b10: begin
        p = k % (2 * N - 2);
        if (p >= N) p = 2 * N - 2 - p;
        return 8'(1 << p);
      end
      default: return 8'((1 << ((k % N) + 1)) - 1);
    endcase
  endfunction

  function automatic logic [7:0] pat_of_state(input model_t s);
    return s.run ? pattern_of(s.md, s.k) : 8'h01;
  endfunction

  always_comb begin
    m_nx       = m;
    m_nx.pulse = 1'b0;
    if (!m.run) begin
      if (start && !stop) begin
        m_nx.run    = 1'b1;
        m_nx.paused = 1'b0;
        m_nx.md     = mode;
        m_nx.per    = period_of(freq_set);
        m_nx.k      = 0;
        m_nx.c      = 1;
      end
    end else if (stop) begin
      m_nx.run    = 1'b0;
      m_nx.paused = 1'b0;
      m_nx.k      = 0;
      m_nx.c      = 1;
    end else if (m.paused) begin
      if (!pause) m_nx.paused = 1'b0;
    end else if (pause) begin
      m_nx.paused = 1'b1;
    end else if (m.c == m.per) begin
      m_nx.c     = 1;
      m_nx.k     = m.k + 1;
      m_nx.pulse = 1'b1;
    end else begin
      m_nx.c = m.c + 1;
    end
`ifdef WATERFALL_PWM_EN
    m_nx.pwm = m.pwm + 4'd1;
    m_nx.led = pat_of_state(m) & {8{m.pwm < brightness}};
`else
    m_nx.led = pat_of_state(m_nx);
`endif
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= M_RST;
    else        m <= m_nx;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Literal LED expectation; with PWM gating the literal pins the model pattern.
  task automatic lit_led(input string name, input logic [7:0] exp);
`ifdef WATERFALL_PWM_EN
    chk(name, {24'b0, pat_of_state(m)}, {24'b0, exp});
`else
    chk(name, {24'b0, led}, {24'b0, exp});
`endif
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("led", {24'b0, led}, {24'b0, m.led});
      chk("busy", {31'b0, busy}, {31'b0, m.run});
      chk("step_pulse", {31'b0, step_pulse}, {31'b0, m.pulse});
    end
  end

  task automatic do_start(input logic [1:0] md, input logic [1:0] f);
    mode = md; freq_set = f; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  initial begin
    int hi;
    // Reset state
    tick(2);
    chk("reset led", {24'b0, led}, 32'h01);
    chk("reset busy", {31'b0, busy}, 32'h0);
    chk("reset step_pulse", {31'b0, step_pulse}, 32'h0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick(2);

    // 1: rotate left, 3 clocks per step
    do_start(2'b00, 2'b00);
    lit_led("t1 initial", 8'h01);
    chk("t1 busy", {31'b0, busy}, 32'h1);
    tick(3);
    lit_led("t1 first step", 8'h02);
    chk("t1 first pulse", {31'b0, step_pulse}, 32'h1);
    tick(21);
    lit_led("t1 wrap", 8'h01);
    tick(4);
    do_stop();
    lit_led("t1 stop led", 8'h01);
    chk("t1 stop busy", {31'b0, busy}, 32'h0);

    // 2: bounce, step every clock
    do_start(2'b10, 2'b11);
    tick(7);
    lit_led("t2 top", 8'h80);
    tick(1);
    lit_led("t2 turn down", 8'h40);
    tick(6);
    lit_led("t2 bottom", 8'h01);
    tick(1);
    lit_led("t2 turn up", 8'h02);
    tick(5);
    do_stop();

    // 3: fill, 2 clocks per step, then pause
    do_start(2'b11, 2'b10);
    tick(14);
    lit_led("t3 full", 8'hFF);
    tick(2);
    lit_led("t3 wrap", 8'h01);
    tick(1);
    pause = 1'b1;
    tick(10);
    lit_led("t3 frozen", 8'h01);
    chk("t3 paused busy", {31'b0, busy}, 32'h1);
    pause = 1'b0;
    tick(1);
    lit_led("t3 resume hold", 8'h01);
    tick(1);
    lit_led("t3 resume step", 8'h03);

    // 4: start ignored in RUN; start+stop together; pause drop with stop
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    chk("t4 start+stop busy", {31'b0, busy}, 32'h0);
    lit_led("t4 start+stop led", 8'h01);
    do_start(2'b01, 2'b01);
    lit_led("t4 rot-right init", 8'h80);
    tick(5);
    lit_led("t4 rot-right step", 8'h40);
    pause = 1'b1;
    tick(3);
    pause = 1'b0; stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("t4 pause-drop stop busy", {31'b0, busy}, 32'h0);

    // 5: asynchronous reset mid-run
    do_start(2'b00, 2'b00);
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 async led", {24'b0, led}, 32'h01);
    chk("t5 async busy", {31'b0, busy}, 32'h0);
    chk("t5 async pulse", {31'b0, step_pulse}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    chk("t5 stays idle", {31'b0, busy}, 32'h0);
    lit_led("t5 idle led", 8'h01);

`ifdef WATERFALL_PWM_EN
    // 6: PWM duty in IDLE (pattern bit0)
    brightness = 4'd4;
    tick(2);
    hi = 0;
    repeat (16) begin
      tick(1);
      if (led[0]) hi++;
    end
    chk("t6 duty 4/16", hi, 32'd4);
    brightness = 4'd0;
    tick(2);
    hi = 0;
    repeat (16) begin
      tick(1);
      if (led != 8'h00) hi++;
    end
    chk("t6 dark", hi, 32'd0);
`else
    hi = 0;
`endif

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end
endmodule
